// File: rtl/arb8_rr.sv
// arb8_rr: round-robin arbiter for eight requesters with hold-time limit.
//
// Ports:
//   clk      in   1  clock, rising edge
//   rst      in   1  synchronous active-high reset
//   req      in   8  request vector, bit i = requester i
//   gnt      out  8  registered one-hot grant, zero when idle
//   gnt_id   out  3  registered index of granted requester (held while idle)
//   busy     out  1  OR of gnt
//   any_req  out  1  OR of req (combinational)
//   timeout  out  1  one-cycle pulse after a forced release
//
// MAX_HOLD sets the longest tenure in cycles; 0 removes the limit.
module arb8_rr #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       busy,
    output logic       any_req,
    output logic       timeout
);

    localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);
    localparam bit            LIMIT_ON = (MAX_HOLD != 0);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_e;

    state_e        state_q;
    logic [7:0]    gnt_q;
    logic [2:0]    gnt_id_q;
    logic [2:0]    last_q;
    logic [CW-1:0] cnt_q;
    logic          timeout_q;

    logic [2:0]    sel_d;
    logic [2:0]    idx;
    logic          found;
    logic [CW-1:0] cnt_d;

    assign any_req = |req;
    assign busy    = |gnt_q;
    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign timeout = timeout_q;

    // Scan last+1 .. last+8 (mod 8); the final step lands on last itself,
    // so the previous owner is considered only after everyone else.
    always_comb begin
        sel_d = last_q;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = last_q + 3'(i);
            if (!found && req[idx]) begin
                sel_d = idx;
                found = 1'b1;
            end
        end
    end

    // Saturating tenure counter; with no limit it parks at its maximum.
    assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            gnt_q     <= 8'h00;
            gnt_id_q  <= 3'd7;
            last_q    <= 3'd7;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (found) begin
                        state_q  <= S_GRANT;
                        gnt_q    <= 8'h01 << sel_d;
                        gnt_id_q <= sel_d;
                        last_q   <= sel_d;
                        cnt_q    <= CW'(1);
                    end
                end
                S_GRANT: begin
                    if (!req[gnt_id_q]) begin
                        state_q <= S_IDLE;
                        gnt_q   <= 8'h00;
                    end else if (LIMIT_ON && cnt_q == HOLD_LIM) begin
                        state_q   <= S_IDLE;
                        gnt_q     <= 8'h00;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb8_rr.sv
// tb_arb8_rr: directed self-checking bench for arb8_rr (MAX_HOLD=4).
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_arb8_rr;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       any_req;
    logic       timeout;

    int vecs;
    int errs;

    arb8_rr #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .any_req (any_req),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200us");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            vecs++;
            if ({gnt, gnt_id, timeout} !== {8'h00, 3'd7, 1'b0}) begin
                errs++;
                $display("FAIL reset_hold: got gnt=%h id=%0d to=%b, want 00/7/0",
                         gnt, gnt_id, timeout);
            end
        end
        rst = 1'b0;
        tick();
        vecs++;
        if ({gnt, gnt_id, busy} !== {8'h01, 3'd0, 1'b1}) begin
            errs++;
            $display("FAIL reset_first: got gnt=%h id=%0d busy=%b, want 01/0/1",
                     gnt, gnt_id, busy);
        end
        req = 8'h00;
        tick();
        vecs++;
        if ({gnt, gnt_id, busy} !== {8'h00, 3'd0, 1'b0}) begin
            errs++;
            $display("FAIL reset_release: got gnt=%h id=%0d busy=%b, want 00/0/0",
                     gnt, gnt_id, busy);
        end
    endtask

    task automatic test_single;
        for (int i = 0; i < 3; i++) begin
            req = 8'h08;
            #1;
            vecs++;
            if (any_req !== 1'b1) begin
                errs++;
                $display("FAIL single_anyreq_hi: got %b, want 1", any_req);
            end
            tick();
            vecs++;
            if ({gnt, gnt_id, busy, timeout} !== {8'h08, 3'd3, 1'b1, 1'b0}) begin
                errs++;
                $display("FAIL single_grant[%0d]: got gnt=%h id=%0d busy=%b to=%b, want 08/3/1/0",
                         i, gnt, gnt_id, busy, timeout);
            end
        end
        req = 8'h00;
        #1;
        vecs++;
        if (any_req !== 1'b0) begin
            errs++;
            $display("FAIL single_anyreq_lo: got %b, want 0", any_req);
        end
        tick();
        vecs++;
        if ({gnt, gnt_id, busy} !== {8'h00, 3'd3, 1'b0}) begin
            errs++;
            $display("FAIL single_release: got gnt=%h id=%0d busy=%b, want 00/3/0",
                     gnt, gnt_id, busy);
        end
    endtask

    task automatic test_fairness;
        logic [7:0] exp_g;
        logic [2:0] exp_id;
        req = 8'h00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            exp_id = 3'(k % 8);
            exp_g  = 8'h01 << exp_id;
            for (int c = 0; c < 2; c++) begin
                tick();
                vecs++;
                if ({gnt, gnt_id, busy} !== {exp_g, exp_id, 1'b1}) begin
                    errs++;
                    $display("FAIL rr_grant[%0d.%0d]: got gnt=%h id=%0d, want %h/%0d",
                             k, c, gnt, gnt_id, exp_g, exp_id);
                end
            end
            req = 8'hFF & ~exp_g;
            tick();
            vecs++;
            if ({gnt, busy} !== {8'h00, 1'b0}) begin
                errs++;
                $display("FAIL rr_idle[%0d]: got gnt=%h busy=%b, want 00/0",
                         k, gnt, busy);
            end
            req = 8'hFF;
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_wrap;
        req = 8'h40;
        tick();
        vecs++;
        if ({gnt, gnt_id} !== {8'h40, 3'd6}) begin
            errs++;
            $display("FAIL wrap_g6: got gnt=%h id=%0d, want 40/6", gnt, gnt_id);
        end
        req = 8'h00;
        tick();
        req = 8'h21;
        tick();
        vecs++;
        if ({gnt, gnt_id} !== {8'h01, 3'd0}) begin
            errs++;
            $display("FAIL wrap_g0: got gnt=%h id=%0d, want 01/0", gnt, gnt_id);
        end
        req = 8'h20;
        tick();
        vecs++;
        if (gnt !== 8'h00) begin
            errs++;
            $display("FAIL wrap_idle: got gnt=%h, want 00", gnt);
        end
        tick();
        vecs++;
        if ({gnt, gnt_id} !== {8'h20, 3'd5}) begin
            errs++;
            $display("FAIL wrap_g5: got gnt=%h id=%0d, want 20/5", gnt, gnt_id);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_timeout;
        logic [7:0] exp_g[11];
        logic       exp_t[11];
        exp_g = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h00,
                  8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h04};
        exp_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'h84;
        for (int i = 0; i < 11; i++) begin
            tick();
            vecs++;
            if ({gnt, timeout} !== {exp_g[i], exp_t[i]}) begin
                errs++;
                $display("FAIL timeout_seq[%0d]: got gnt=%h to=%b, want %h/%b",
                         i, gnt, timeout, exp_g[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        req = 8'h10;
        tick();
        tick();
        vecs++;
        if ({gnt, gnt_id} !== {8'h10, 3'd4}) begin
            errs++;
            $display("FAIL mid_setup: got gnt=%h id=%0d, want 10/4", gnt, gnt_id);
        end
        rst = 1'b1;
        tick();
        vecs++;
        if ({gnt, gnt_id, busy, timeout} !== {8'h00, 3'd7, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL mid_drop: got gnt=%h id=%0d busy=%b to=%b, want 00/7/0/0",
                     gnt, gnt_id, busy, timeout);
        end
        rst = 1'b0;
        tick();
        vecs++;
        if ({gnt, gnt_id} !== {8'h10, 3'd4}) begin
            errs++;
            $display("FAIL mid_regrant: got gnt=%h id=%0d, want 10/4", gnt, gnt_id);
        end
        req = 8'h00;
        tick();
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst  = 1'b1;
        req  = 8'h00;
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
